// File: rtl/dco_meas_pkg.sv
// rtl/dco_meas_pkg.sv - shared types and default widths for the DCO frequency meter
//
// Purpose:
//   Holds the measurement FSM state type and the default parameter values
//   used by dco_freq_meter and osc_edge_sync.
//
// Contents:
//   GATE_W_DEF       default gate-window counter width
//   CNT_W_DEF        default edge counter / result width
//   SYNC_STAGES_DEF  default synchronizer depth on the oscillator input
//   meas_state_e     IDLE / COUNT / HOLD

package dco_meas_pkg;

  localparam int GATE_W_DEF      = 16;
  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } meas_state_e;

endpackage

// File: rtl/osc_edge_sync.sv
// rtl/osc_edge_sync.sv - synchronizer chain plus registered rising-edge detector
//
// Purpose:
//   Brings an asynchronous DCO-derived signal into the clk domain and emits a
//   one-cycle pulse for each rising edge seen after synchronization.
//   Latency from an async_in rise to edge_pulse is SYNC_STAGES+1 clk cycles.
//   Only input frequencies below f_clk/2 produce one pulse per edge.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   async_in    in   asynchronous input
//   edge_pulse  out  one-cycle pulse per synchronized rising edge
//
// SYNC_STAGES must be at least 2.

module osc_edge_sync
  import dco_meas_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q     <= sync_out;
      // Registered so the pulse is glitch-free and the downstream counter
      // sees a clean flop output.
      edge_pulse <= sync_out & ~prev_q;
    end
  end

endmodule

// File: rtl/dco_freq_meter.sv
// rtl/dco_freq_meter.sv - DCO frequency meter: counts osc_in edges over a clk gate window
//
// Purpose:
//   On an accepted start, counts synchronized rising edges of osc_in for
//   gate_cycles clk cycles, then presents the count on a valid/ready port.
//   The edge counter saturates at all-ones and flags overflow.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   block enable; low returns to IDLE and discards work
//   start        in   single-cycle measurement request (IDLE only)
//   gate_cycles  in   window length in clk cycles, sampled on accepted start
//   osc_in       in   asynchronous DCO output
//   cnt_out      out  measured edge count, updated on entry to HOLD
//   cnt_valid    out  result available
//   cnt_ready    in   consumer accepts result
//   overflow     out  edge counter saturated during the window (sticky)
//   busy         out  state is not IDLE

module dco_freq_meter
  import dco_meas_pkg::*;
#(
  parameter int GATE_W      = GATE_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              osc_in,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              cnt_valid,
  input  logic              cnt_ready,
  output logic              overflow,
  output logic              busy
);

  meas_state_e       state_q;
  meas_state_e       state_d;
  logic [GATE_W-1:0] gate_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_d;
  logic              edge_pulse;
  logic              cnt_sat;
  logic              last_gate;
  logic              start_ok;

  osc_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (osc_in),
    .edge_pulse (edge_pulse)
  );

  assign cnt_sat   = &edge_cnt_q;
  assign last_gate = (gate_q == GATE_W'(1));
  assign start_ok  = start && (gate_cycles != '0);

  // Next edge count including this cycle's edge; used both for the running
  // counter and for the final capture into cnt_out.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (edge_pulse && !cnt_sat) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok) state_d = COUNT;
        COUNT:   if (last_gate) state_d = HOLD;
        // cnt_valid is high throughout HOLD, so ready alone completes it.
        HOLD:    if (cnt_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      cnt_valid  <= 1'b0;
      cnt_out    <= '0;
      overflow   <= 1'b0;
      gate_q     <= '0;
      edge_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != IDLE);
      cnt_valid <= (state_d == HOLD);

      case (state_q)
        IDLE: begin
          if (state_d == COUNT) begin
            gate_q     <= gate_cycles;
            edge_cnt_q <= '0;
            overflow   <= 1'b0;
          end
        end
        COUNT: begin
          if (ena) begin
            gate_q     <= gate_q - GATE_W'(1);
            edge_cnt_q <= edge_cnt_d;
            if (edge_pulse && cnt_sat) begin
              overflow <= 1'b1;
            end
            if (last_gate) begin
              cnt_out <= edge_cnt_d;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dco_freq_meter.sv
// tb/tb_dco_freq_meter.sv - self-checking bench for dco_freq_meter

module tb_dco_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        start_a;
  logic        start_b;
  logic [15:0] gate_cycles;
  logic        osc_in = 1'b0;
  logic        cnt_ready;

  logic [15:0] cnt_a;
  logic        valid_a, ovf_a, busy_a;
  logic [3:0]  cnt_b;
  logic        valid_b, ovf_b, busy_b;

  bit          sel;
  logic [15:0] obs_cnt;
  logic        obs_valid, obs_ovf, obs_busy;

  int          osc_half = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    int cnt;
    int ovf;
    int tol;
  } exp_t;

  exp_t sb[$];

  dco_freq_meter u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start       (start_a),
    .gate_cycles (gate_cycles),
    .osc_in      (osc_in),
    .cnt_out     (cnt_a),
    .cnt_valid   (valid_a),
    .cnt_ready   (cnt_ready),
    .overflow    (ovf_a),
    .busy        (busy_a)
  );

  dco_freq_meter #(.CNT_W(4)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start       (start_b),
    .gate_cycles (gate_cycles),
    .osc_in      (osc_in),
    .cnt_out     (cnt_b),
    .cnt_valid   (valid_b),
    .cnt_ready   (cnt_ready),
    .overflow    (ovf_b),
    .busy        (busy_b)
  );

  always #10 clk = ~clk;

  always begin
    if (osc_half == 0) begin
      osc_in = 1'b0;
      @(posedge clk);
    end else begin
      #(osc_half);
      osc_in = ~osc_in;
    end
  end

  always_comb begin
    obs_cnt   = sel ? {12'b0, cnt_b} : cnt_a;
    obs_valid = sel ? valid_b : valid_a;
    obs_ovf   = sel ? ovf_b : ovf_a;
    obs_busy  = sel ? busy_b : busy_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic check_cnt(input string tag, input exp_t e);
    int diff;
    diff = int'(obs_cnt) - e.cnt;
    if (diff < 0) diff = -diff;
    chk(tag, int'(diff <= e.tol), 1);
  endtask

  // One full measurement: push expectation, start, wait for result,
  // compare against the popped expectation, optionally stall, then accept.
  task automatic measure(input int g, input int exp_cnt, input int exp_ovf,
                         input int tol, input int hold);
    exp_t e;
    int   n;
    sb.push_back('{cnt: exp_cnt, ovf: exp_ovf, tol: tol});
    gate_cycles = 16'(g);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    chk("busy_after_start", int'(obs_busy), 1);
    n = 1;
    while (!obs_valid && n < g + 20) begin
      tick();
      n++;
    end
    chk("valid_latency", n, g + 1);
    e = sb.pop_front();
    check_cnt("cnt_out", e);
    chk("overflow", int'(obs_ovf), e.ovf);
    for (int i = 0; i < hold; i++) begin
      gate_cycles = 16'd5;
      set_start(i[0]);
      tick();
      chk("hold_valid", int'(obs_valid), 1);
      check_cnt("hold_cnt", e);
    end
    cnt_ready = 1'b1;
    set_start(hold > 0);
    tick();
    cnt_ready = 1'b0;
    set_start(1'b0);
    chk("valid_after_accept", int'(obs_valid), 0);
    chk("busy_after_accept", int'(obs_busy), 0);
  endtask

  task automatic quiet_osc();
    osc_half = 0;
    repeat (10) tick();
  endtask

  initial begin
    int vcount;
    rst_n       = 1'b0;
    ena         = 1'b1;
    start_a     = 1'b0;
    start_b     = 1'b0;
    gate_cycles = '0;
    cnt_ready   = 1'b0;
    sel         = 1'b0;
    #25;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Nominal: 200 ns period, 200-cycle window -> 20 edges
    osc_half = 100;
    repeat (10) tick();
    measure(200, 20, 0, 1, 0);

    // Static input
    quiet_osc();
    measure(50, 0, 0, 0, 0);
    measure(1, 0, 0, 0, 0);

    // Saturation on the 4-bit instance, then overflow must clear
    sel = 1'b1;
    osc_half = 40;
    repeat (10) tick();
    measure(100, 15, 1, 0, 0);
    quiet_osc();
    measure(20, 0, 0, 0, 0);
    sel = 1'b0;

    // Backpressure with start pulses during HOLD: 100-cycle window -> 10 edges
    osc_half = 100;
    repeat (10) tick();
    measure(100, 10, 0, 1, 50);

    // start with zero window is ignored
    gate_cycles = 16'd0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("zero_gate_busy", int'(busy_a), 0);
    tick();
    chk("zero_gate_busy2", int'(busy_a), 0);

    // ena dropped at cycle 30 of a 100-cycle window
    gate_cycles = 16'd100;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (29) tick();
    chk("abort_busy_before", int'(busy_a), 1);
    ena = 1'b0;
    tick();
    chk("abort_busy", int'(busy_a), 0);
    ena = 1'b1;
    vcount = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (valid_a) vcount++;
    end
    chk("abort_no_valid", vcount, 0);

    // Asynchronous reset mid-count
    gate_cycles = 16'd100;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (20) tick();
    chk("pre_reset_busy", int'(busy_a), 1);
    #6;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy_a), 0);
    chk("async_rst_valid", int'(valid_a), 0);
    chk("async_rst_cnt", int'(cnt_a), 0);
    chk("async_rst_ovf", int'(ovf_a), 0);
    #5;
    rst_n = 1'b1;
    repeat (5) tick();
    measure(200, 20, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
